// File: rtl/cpm_sparse_pack.sv
// cpm_sparse_pack: two-stage feeder for the CPM multi-input FIFO.
// Stage 1 captures a lane vector plus valid mask. Stage 2 holds the same vector
// compacted to the low lanes, lowest lane first, together with its popcount.
// A single multi-word push is issued only when the FIFO reports enough free
// slots. Vectors with an all-zero mask retire without a push and are counted
// as drops. The design also keeps a running count of pushed words.
module cpm_sparse_pack #(
    parameter int DATA_WIDTH = 64,
    parameter int DATA_NUMAW = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clr,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [(2**DATA_NUMAW)*DATA_WIDTH-1:0]  in_data,
    input  logic [(2**DATA_NUMAW)-1:0]             in_mask,
    input  logic [ADDR_WIDTH:0]                    fifo_count_empty,
    output logic                                   push,
    output logic [(2**DATA_NUMAW)*DATA_WIDTH-1:0]  fifo_data,
    output logic [DATA_NUMAW-1:0]                  fifo_data_num,
    output logic [CNT_WIDTH-1:0]                   word_cnt,
    output logic [CNT_WIDTH-1:0]                   drop_cnt
);
    localparam int DATA_MAX_N = 2**DATA_NUMAW;
    localparam int VEC_W      = DATA_MAX_N*DATA_WIDTH;

    logic                    v1_reg;
    logic                    v2_reg;
    logic [VEC_W-1:0]        data1_reg;
    logic [VEC_W-1:0]        data2_reg;
    logic [DATA_MAX_N-1:0]   mask1_reg;
    logic [DATA_NUMAW:0]     cnt2_reg;
    logic [CNT_WIDTH-1:0]    word_cnt_reg;
    logic [CNT_WIDTH-1:0]    drop_cnt_reg;

    logic [DATA_NUMAW:0]     prefix [0:DATA_MAX_N];
    logic [VEC_W-1:0]        pack_next;
    logic [DATA_NUMAW:0]     cnt_next;
    logic [DATA_NUMAW:0]     cnt2_m1;
    logic                    space_ok;
    logic                    fire2;
    logic                    adv1;
    logic                    accept;

    // Running popcount of the stage-1 mask: prefix[i] counts set lanes below lane i.
    always_comb begin
        prefix[0] = '0;
        for (int i = 0; i < DATA_MAX_N; i++) begin
            prefix[i+1] = prefix[i] + (DATA_NUMAW+1)'(mask1_reg[i]);
        end
    end

    assign cnt_next = prefix[DATA_MAX_N];

    // Each output lane picks the input lane whose rank among set lanes equals its index.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_MAX_N; gi++) begin : g_lane
            localparam logic [DATA_NUMAW:0] LANE_IDX = (DATA_NUMAW+1)'(gi);
            logic [DATA_WIDTH-1:0] lane_word;

            // Select the single matching source lane; unmatched output lanes stay zero.
            always_comb begin
                lane_word = '0;
                for (int i = 0; i < DATA_MAX_N; i++) begin
                    if (mask1_reg[i] && (prefix[i] == LANE_IDX)) begin
                        lane_word = data1_reg[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            assign pack_next[gi*DATA_WIDTH +: DATA_WIDTH] = lane_word;
        end
    endgenerate

    // Stage-2 retire and stage-1 advance conditions.
    // fifo_count_empty is already registered in the FIFO, so no extra margin is needed.
    assign space_ok = (fifo_count_empty >= (ADDR_WIDTH+1)'(cnt2_reg));
    assign fire2    = v2_reg && ((cnt2_reg == '0) || space_ok);
    assign adv1     = v1_reg && (!v2_reg || fire2);
    assign in_ready = !v1_reg || adv1;
    assign accept   = in_valid && in_ready;

    assign cnt2_m1       = cnt2_reg - (DATA_NUMAW+1)'(1);
    assign push          = v2_reg && (cnt2_reg != '0) && space_ok;
    assign fifo_data     = data2_reg;
    assign fifo_data_num = (cnt2_reg == '0) ? '0 : cnt2_m1[DATA_NUMAW-1:0];
    assign word_cnt      = word_cnt_reg;
    assign drop_cnt      = drop_cnt_reg;

    // Pipeline registers and statistics; reset and clr discard anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            v1_reg       <= 1'b0;
            v2_reg       <= 1'b0;
            data1_reg    <= '0;
            mask1_reg    <= '0;
            data2_reg    <= '0;
            cnt2_reg     <= '0;
            word_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (accept) begin
                v1_reg    <= 1'b1;
                data1_reg <= in_data;
                mask1_reg <= in_mask;
            end else if (adv1) begin
                v1_reg <= 1'b0;
            end

            if (adv1) begin
                v2_reg    <= 1'b1;
                data2_reg <= pack_next;
                cnt2_reg  <= cnt_next;
            end else if (fire2) begin
                v2_reg <= 1'b0;
            end

            if (push) begin
                word_cnt_reg <= word_cnt_reg + CNT_WIDTH'(cnt2_reg);
            end
            if (v2_reg && (cnt2_reg == '0)) begin
                drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_cpm_sparse_pack.sv
// Testbench for cpm_sparse_pack: stimulus pushes expected compacted vectors into
// a scoreboard queue; an independent negedge monitor pops and compares on push.
module tb_cpm_sparse_pack;
    localparam int W     = 64;
    localparam int NUMAW = 3;
    localparam int N     = 8;
    localparam int AW    = 4;
    localparam int CW    = 16;
    localparam int VW    = N*W;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [VW-1:0]     in_data;
    logic [N-1:0]      in_mask;
    logic [AW:0]       fifo_count_empty;
    logic              push;
    logic [VW-1:0]     fifo_data;
    logic [NUMAW-1:0]  fifo_data_num;
    logic [CW-1:0]     word_cnt;
    logic [CW-1:0]     drop_cnt;

    cpm_sparse_pack #(
        .DATA_WIDTH (W),
        .DATA_NUMAW (NUMAW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clr              (clr),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_mask          (in_mask),
        .fifo_count_empty (fifo_count_empty),
        .push             (push),
        .fifo_data        (fifo_data),
        .fifo_data_num    (fifo_data_num),
        .word_cnt         (word_cnt),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [VW-1:0] exp_data_q [$];
    int            exp_num_q  [$];
    int            exp_words  = 0;
    int            exp_drops  = 0;

    logic          fifo_model_en = 1'b0;
    logic [AW:0]   fixed_empty   = 5'd16;
    logic [AW:0]   model_empty   = 5'd16;
    int            occ           = 0;
    int            pend_words    = 0;

    assign fifo_count_empty = fifo_model_en ? model_empty : fixed_empty;

    // Reference compaction: gather the set lanes in ascending order into a list.
    function automatic logic [VW-1:0] compact(input logic [VW-1:0] d, input logic [N-1:0] m,
                                              output int cnt);
        logic [W-1:0]  words [$];
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) words.push_back(d[i*W +: W]);
        end
        foreach (words[k]) r[k*W +: W] = words[k];
        cnt = words.size();
        return r;
    endfunction

    task automatic check(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every push the DUT will make at the next edge is compared with the scoreboard head.
    always @(negedge clk) begin
        logic [VW-1:0] edata;
        int            enum_v;
        pend_words = 0;
        if (rst_n && !clr && push) begin
            pend_words = int'(fifo_data_num) + 1;
            tests++;
            if (exp_data_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_push: got push=1 num=%0d, required no push", fifo_data_num);
            end else begin
                edata  = exp_data_q.pop_front();
                enum_v = exp_num_q.pop_front();
                if (fifo_data !== edata || int'(fifo_data_num) != enum_v) begin
                    fails++;
                    $display("FAIL push_data: got num=%0d data=%h, required num=%0d data=%h",
                             fifo_data_num, fifo_data, enum_v, edata);
                end else begin
                    $display("[TB] push num=%0d words=%0d ok", fifo_data_num, pend_words);
                end
            end
        end
    end

    // Downstream FIFO model: depth 16, drained one word per cycle, registered free count.
    always @(posedge clk) begin
        #1;
        if (!fifo_model_en) begin
            occ         = 0;
            model_empty = 5'(DEPTH);
        end else begin
            if (pend_words > 0) begin
                tests++;
                if (occ + pend_words > DEPTH) begin
                    fails++;
                    $display("FAIL fifo_overflow: got occupancy %0d, required <= %0d", occ + pend_words, DEPTH);
                end
            end
            occ = occ - ((occ > 0) ? 1 : 0) + pend_words;
            if (occ > DEPTH) occ = DEPTH;
            model_empty = 5'(DEPTH - occ);
        end
    end

    // Present one vector, wait (bounded) for acceptance, and record its expected result.
    task automatic send(input logic [VW-1:0] d, input logic [N-1:0] m, output int waited);
        int            acc;
        int            cnt;
        logic [VW-1:0] ev;
        acc      = 0;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        while (acc == 0 && waited <= 300) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            else          waited++;
            if (acc == 0) tick();
        end
        check("accept", acc, 1);
        if (acc != 0) begin
            ev = compact(d, m, cnt);
            if (cnt != 0) begin
                exp_data_q.push_back(ev);
                exp_num_q.push_back(cnt - 1);
            end else begin
                exp_drops++;
            end
            exp_words += cnt;
            tick();
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain;
        int b;
        b = 0;
        while (exp_data_q.size() > 0 && b < 400) begin
            tick();
            b++;
        end
        check("drain_queue_left", exp_data_q.size(), 0);
        repeat (3) tick();
        @(negedge clk);
        check("word_cnt", int'(word_cnt), exp_words % 65536);
        check("drop_cnt", int'(drop_cnt), exp_drops % 65536);
        tick();
    endtask

    task automatic do_clr;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_data_q.delete();
        exp_num_q.delete();
        exp_words = 0;
        exp_drops = 0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = {$urandom(), $urandom()};
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] d;
        logic [N-1:0]  m;
        int            wt;

        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_mask  = '0;

        // Reset
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_push", int'(push), 0);
        check("rst_num", int'(fifo_data_num), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_word_cnt", int'(word_cnt), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_fifo_data_zero", int'(fifo_data == '0), 1);
        tick();

        // Single vector with lanes holding their index, latency two cycles
        fixed_empty = 5'd16;
        for (int i = 0; i < N; i++) d[i*W +: W] = 64'(i);
        send(d, 8'b1010_0101, wt);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_no_push_s1", int'(push), 0);
        tick();
        @(negedge clk);
        check("lat_push_s2", int'(push), 1);
        check("single_num", int'(fifo_data_num), 3);
        tick();
        wait_drain();
        check("single_word_cnt_4", int'(word_cnt), 4);

        // Backpressure: 4-word vector stalls on 3 free slots
        fixed_empty = 5'd3;
        send(rand_vec(), 8'h0F, wt);
        send(rand_vec(), 8'h30, wt);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_push", int'(push), 0);
            check("stall_in_ready", int'(in_ready), 0);
            tick();
        end
        fixed_empty = 5'd4;
        wait_drain();

        // Streaming: 10 full vectors into a depth-16 FIFO model
        do_clr();
        fifo_model_en = 1'b1;
        for (int k = 0; k < 10; k++) send(rand_vec(), 8'hFF, wt);
        in_valid = 1'b0;
        wait_drain();
        check("stream_word_cnt_80", int'(word_cnt), 80);
        fifo_model_en = 1'b0;

        // Zero masks are absorbed without stalling the producer
        do_clr();
        fixed_empty = 5'd16;
        send(rand_vec(), 8'h00, wt);
        check("zero_ready_0", wt, 0);
        send(rand_vec(), 8'h01, wt);
        check("zero_ready_1", wt, 0);
        send(rand_vec(), 8'h00, wt);
        check("zero_ready_2", wt, 0);
        in_valid = 1'b0;
        wait_drain();
        check("zero_drop_cnt_2", int'(drop_cnt), 2);

        // Randomised traffic against the FIFO model
        do_clr();
        fifo_model_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            send(rand_vec(), m, wt);
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        in_valid = 1'b0;
        wait_drain();
        fifo_model_en = 1'b0;

        // clr with both stages holding stalled vectors
        fixed_empty = 5'd0;
        send(rand_vec(), 8'h0F, wt);
        send(rand_vec(), 8'hFF, wt);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_clr_in_ready", int'(in_ready), 0);
        check("pre_clr_push", int'(push), 0);
        tick();
        do_clr();
        fixed_empty = 5'd16;
        @(negedge clk);
        check("clr_push", int'(push), 0);
        check("clr_in_ready", int'(in_ready), 1);
        check("clr_word_cnt", int'(word_cnt), 0);
        check("clr_drop_cnt", int'(drop_cnt), 0);
        tick();
        repeat (6) tick();
        @(negedge clk);
        check("post_clr_word_cnt", int'(word_cnt), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpm_sparse_pack.md
Name: cpm_sparse_pack

Overview:
- Upstream feeder for the CPM multi-input FIFO.
- Accepts a vector of DATA_MAX_N words plus a per-lane valid mask. Compacts the valid lanes to the low end, lowest lane first.
- Issues a single multi-word push (push / data_in / data_in_num) only when the FIFO reports enough free slots. All-zero-mask vectors are absorbed without a push.
- Two-stage pipeline with ready/valid backpressure toward the producer. Keeps word and drop statistics.

Parameters:
- DATA_WIDTH, 64, width of one word.
- DATA_NUMAW, 3, width of fifo_data_num; DATA_MAX_N = 2**DATA_NUMAW.
- ADDR_WIDTH, 4, FIFO address width; fifo_count_empty is ADDR_WIDTH+1 bits.
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- clr  in  1  synchronous clear of pipeline and counters, same effect as rst_n
- in_valid  in  1  producer vector valid
- in_ready  out  1  block can accept vector this cycle
- in_data  in  DATA_MAX_N*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_mask  in  DATA_MAX_N  lane i valid when bit i = 1
- fifo_count_empty  in  ADDR_WIDTH+1  free slots reported by downstream FIFO
- push  out  1  FIFO push strobe
- fifo_data  out  DATA_MAX_N*DATA_WIDTH  compacted words, lane 0 = first
- fifo_data_num  out  DATA_NUMAW  number of valid words minus 1
- word_cnt  out  CNT_WIDTH  total words pushed
- drop_cnt  out  CNT_WIDTH  vectors with all-zero mask

Behaviour:
- Reset/clr, at the rising edge with rst_n=0 or clr=1:
  - Clears v1, v2, S1/S2 data, cnt2, word_cnt and drop_cnt to 0.
  - Resulting outputs: push=0, fifo_data=0, fifo_data_num=0, in_ready=1.
  - rst_n has priority over clr. Any vector in flight is discarded, no push.
- S1: registers in_data and in_mask when in_valid && in_ready.
- S2: registers the compacted S1 vector and the popcount cnt2 (0..DATA_MAX_N, DATA_NUMAW+1 bits).
- Compaction: lane k of S2 holds the k-th set lane of the S1 mask, ascending index. Lanes k >= cnt2 are zero.
- space_ok = (fifo_count_empty >= cnt2), compared at ADDR_WIDTH+1 bits.
- Combinational S2 outputs:
  - fire2 = v2 && (cnt2==0 || space_ok).
  - push = v2 && cnt2!=0 && space_ok.
  - fifo_data = S2 data.
  - fifo_data_num = cnt2-1 truncated to DATA_NUMAW. Drive 0 when cnt2==0.
- Stage handshakes:
  - adv1 = v1 && (!v2 || fire2).
  - in_ready = !v1 || adv1.
  - v2 is set on adv1. It clears on fire2 && !adv1.
- Full throughput: one vector per cycle when the FIFO has space.
- Latency: vector accepted at edge t is in S1 after t. It is compacted into S2 at edge t+1. push is asserted in the cycle after edge t+1 if space_ok.
- Stall: while !space_ok with cnt2>0:
  - S2 holds and push=0.
  - S1 fills; then in_ready=0.
  - No data is lost or reordered.
- fifo_count_empty is the FIFO's registered value. It already reflects a push made on the previous edge, so back-to-back pushes are legal without extra margin.
- Exact fit (fifo_count_empty == cnt2) pushes.
- Zero mask: S2 retires in one cycle with push=0, and drop_cnt increments.
- Counters:
  - word_cnt += cnt2 on each push. drop_cnt += 1 on each zero-mask retire.
  - Both wrap modulo 2**CNT_WIDTH.
- X safety: in_data/in_mask are ignored when in_valid=0.

Test Plan:
- Reset → state and outputs: hold rst_n=0 for 2 cycles, then rst_n=1 → push=0, fifo_data_num=0, in_ready=1, word_cnt=0, drop_cnt=0.
- Single vector: mask=8'b1010_0101, lanes hold value=i, fifo_count_empty=16 → push exactly 2 cycles after accept. fifo_data lanes0..3 = 0,2,5,7, lanes4..7 = 0, fifo_data_num=3, word_cnt=4.
- Backpressure: fifo_count_empty=3, S2 cnt2=4 → push=0 held. in_ready drops after the next accept. Raise fifo_count_empty to 4 → push with the original data and order preserved.
- Streaming: 10 consecutive full-mask vectors (cnt=8), fifo_count_empty driven by a FIFO model of depth 16 drained 1/cycle → no overflow, word_cnt=80, output order equals input order.
- Zero mask: vectors with masks 0x00, 0x01, 0x00 → one push with fifo_data_num=0, drop_cnt=2, in_ready never deasserts.
- Mid-operation reset: clr=1 while S1 and S2 are both valid and stalled → next cycle push=0, in_ready=1, counters=0. No push of the stale data after clr deasserts.
